// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with valid/ack handshake
//
// Receives frames of 1 start bit (0), 8 data bits LSB first and 1 stop bit (1).
// Each bit lasts BAUD_DIV clk cycles. Bits are sampled mid-bit, timed from
// the first synchronized low cycle of the start bit.
//
// Parameters:
//   BAUD_DIV  clk cycles per serial bit (even, 4..256); must match transmitter
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   rx_ack     in   consumer acknowledge; clears rx_valid and overrun
//   data_out   out  [7:0] last received byte
//   rx_valid   out  level; data_out holds an unacknowledged byte
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   overrun    out  sticky; a byte was overwritten before acknowledge
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);

  // Counter compare points. The counter is cleared on the transition into
  // START, so the START cycle with count HALF_LAST is cycle E+BAUD_DIV/2.
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_reg;
  logic            rx_meta_reg;
  logic            rx_s_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      data_out     <= 8'h00;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // Handshake. An ack with nothing pending is ignored. A byte completing
      // in the same cycle overrides these assignments further down.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg    <= START;
            baud_cnt_reg <= '0;
            busy         <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= '0;
            if (!rx_s_reg) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end

        DATA: begin
          if (baud_cnt_reg == FULL_LAST) begin
            baud_cnt_reg <= '0;
            // LSB first: after eight right shifts the first bit sits in bit 0.
            shift_reg <= {rx_s_reg, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
            bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end

        STOP: begin
          if (baud_cnt_reg == FULL_LAST) begin
            baud_cnt_reg <= '0;
            if (rx_s_reg) begin
              data_out  <= shift_reg;
              rx_valid  <= 1'b1;
              // Overwriting a pending, unacknowledged byte.
              if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
              end
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_reg <= BREAK;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end

        BREAK: begin
          // Wait out a held-low line so it is not decoded as new start bits.
          if (rx_s_reg) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed testbench for uart_rx (BAUD_DIV = 4)
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         assert_cnt = 0;
  int         fail_cnt   = 0;
  int         ferr_cnt   = 0;
  bit         busy_seen  = 1'b0;
  bit         auto_ack   = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_err === 1'b1) ferr_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (auto_ack) begin
      if (rx_ack) begin
        rx_ack = 1'b0;
      end else if (rx_valid === 1'b1) begin
        got_q.push_back(data_out);
        rx_ack = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) tick();
    end
    rx = stop;
    repeat (BD) tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, {7'd0, rx_valid}, 8'd1);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) tick();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_ferr", {7'd0, frame_err}, 8'd0);
    check("rst_ovr", {7'd0, overrun}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Single frame 0xA5
    ferr_cnt = 0; busy_seen = 1'b0;
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid");
    check("a5_data", data_out, 8'hA5);
    check("a5_ferr_cnt", 8'(ferr_cnt), 8'd0);
    check("a5_busy_seen", {7'd0, busy_seen}, 8'd1);
    check("a5_busy_idle", {7'd0, busy}, 8'd0);
    ack_once();
    check("a5_ack_valid", {7'd0, rx_valid}, 8'd0);
    // Ack with nothing pending does nothing
    ack_once();
    check("idle_ack_valid", {7'd0, rx_valid}, 8'd0);
    check("idle_ack_data", data_out, 8'hA5);
    check("idle_ack_ovr", {7'd0, overrun}, 8'd0);

    // Back-to-back 0x3C, 0xC3 with an ack after each
    got_q.delete();
    auto_ack = 1'b1;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (8) tick();
    auto_ack = 1'b0;
    if (rx_ack) tick();
    rx_ack = 1'b0;
    check("b2b_count", 8'(got_q.size()), 8'd2);
    check("b2b_first", got_q[0], 8'h3C);
    check("b2b_second", got_q[1], 8'hC3);
    check("b2b_ovr", {7'd0, overrun}, 8'd0);
    check("b2b_valid", {7'd0, rx_valid}, 8'd0);

    // Overrun: 0x11 then 0x22 with no ack
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (3) tick();
    check("ovr_data", data_out, 8'h22);
    check("ovr_valid", {7'd0, rx_valid}, 8'd1);
    check("ovr_flag", {7'd0, overrun}, 8'd1);
    ack_once();
    check("ovr_ack_valid", {7'd0, rx_valid}, 8'd0);
    check("ovr_ack_flag", {7'd0, overrun}, 8'd0);

    // Frame error with a pending byte: 0x77 left unacknowledged first
    send_frame(8'h77, 1'b1);
    repeat (3) tick();
    check("pre_ferr_valid", {7'd0, rx_valid}, 8'd1);
    ferr_cnt = 0;
    send_frame(8'hFF, 1'b0);
    repeat (3 * BD) tick();
    rx = 1'b1;
    repeat (10) tick();
    check("ferr_cnt", 8'(ferr_cnt), 8'd1);
    check("ferr_valid", {7'd0, rx_valid}, 8'd1);
    check("ferr_data", data_out, 8'h77);
    check("ferr_ovr", {7'd0, overrun}, 8'd0);
    check("ferr_busy", {7'd0, busy}, 8'd0);
    ack_once();

    // Glitch of BD/2-1 cycles: false start
    ferr_cnt = 0; busy_seen = 1'b0;
    rx = 1'b0;
    repeat (BD / 2 - 1) tick();
    rx = 1'b1;
    repeat (8) tick();
    check("glitch_busy_seen", {7'd0, busy_seen}, 8'd1);
    check("glitch_busy", {7'd0, busy}, 8'd0);
    check("glitch_valid", {7'd0, rx_valid}, 8'd0);
    check("glitch_data", data_out, 8'h77);
    check("glitch_ferr", 8'(ferr_cnt), 8'd0);
    check("glitch_ovr", {7'd0, overrun}, 8'd0);

    // Reset at data bit 4 of a frame
    rx = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 4; i++) begin
      rx = 8'h96 >> i;
      repeat (BD) tick();
    end
    rx = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_valid", {7'd0, rx_valid}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    repeat (3) tick();
    reset = 1'b0;
    ferr_cnt = 0;
    repeat (45) tick();
    check("post_rst_valid", {7'd0, rx_valid}, 8'd0);
    check("post_rst_ferr", 8'(ferr_cnt), 8'd0);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check("post_rst_ovr", {7'd0, overrun}, 8'd0);
    send_frame(8'h5A, 1'b1);
    wait_valid("5a_valid");
    check("5a_data", data_out, 8'h5A);
    check("5a_ferr", 8'(ferr_cnt), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BAUD_DIV, default 4, clk cycles per serial bit; SHALL be even, 4..256, and match the team transmitter's BAUD_DIV.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line, idle high.
REQ-005 rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-006 data_out  output  8  last received byte.
REQ-007 rx_valid  output  1  level; data_out holds an unacknowledged byte.
REQ-008 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 overrun  output  1  sticky; a byte was overwritten before acknowledge.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit BAUD_DIV cycles.
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; the synchronizer resets to 1.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx_s==0 in cycle E -> START, with the baud counter cleared to 0.
REQ-015 START: at cycle E+BAUD_DIV/2, sample rx_s; 0 -> DATA with bit index 0; 1 -> IDLE as a false start, with no output change.
REQ-016 DATA: data bit i (0..7) SHALL be sampled at cycle E+BAUD_DIV/2+(i+1)*BAUD_DIV and shifted into bit i of an internal shift register; after bit 7 -> STOP.
REQ-017 STOP: the stop bit SHALL be sampled at cycle E+BAUD_DIV/2+9*BAUD_DIV.
REQ-018 Stop bit = 1 -> data_out SHALL be loaded with the shift register and rx_valid SHALL be 1 from the next cycle; FSM -> IDLE.
REQ-019 Stop bit = 0 -> frame_err SHALL pulse for exactly one cycle (the next cycle); data_out, rx_valid and overrun SHALL be unchanged; FSM -> BREAK.
REQ-020 BREAK: hold until rx_s==1, then -> IDLE; held-low zeros SHALL NOT be decoded as start bits.
REQ-021 rx_valid SHALL remain 1 until a cycle with rx_ack==1, then clear on the next edge.
REQ-022 rx_ack while rx_valid==0 SHALL have no effect.
REQ-023 Byte completes while rx_valid==1 and rx_ack==0 -> data_out SHALL be overwritten, rx_valid stays 1, overrun set to 1.
REQ-024 Byte completes in the same cycle as rx_ack==1 -> new byte loaded, rx_valid stays 1, overrun cleared/remains 0.
REQ-025 overrun SHALL clear only on rx_ack==1 (except per REQ-024) or reset.
REQ-026 The baud counter SHALL wrap 0..BAUD_DIV-1 within DATA/STOP; a new start edge SHALL be accepted in the cycle immediately after returning to IDLE (back-to-back frames).
REQ-027 The FSM SHALL not act on rx_ack; reception continues regardless of handshake state.

Reset
REQ-028 Reset SHALL force, asynchronously: state IDLE, data_out 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0, counters 0, synchronizer 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without any valid or error pulse; after release, the line SHALL be re-evaluated from IDLE.
REQ-030 After reset release, the first start edge SHALL be recognised no earlier than 2 cycles after rx falls (synchronizer latency).

Verification
REQ-031 BAUD_DIV=4, frame for 8'hA5 -> rx_valid=1 with data_out=8'hA5, frame_err never pulses, busy low after STOP.
REQ-032 Bytes 8'h3C then 8'hC3 sent back-to-back with no idle gap, rx_ack pulsed after each -> two valid bytes, overrun=0.
REQ-033 Two frames (8'h11, 8'h22) with no rx_ack -> data_out=8'h22, rx_valid=1, overrun=1; one rx_ack -> both cleared.
REQ-034 Stop bit driven 0 for 8'hFF, line held low 3*BAUD_DIV cycles, then high -> one frame_err pulse, rx_valid unchanged, no spurious byte, returns to IDLE.
REQ-035 rx low glitch of BAUD_DIV/2-1 cycles -> false start, FSM back in IDLE, no outputs change.
REQ-036 Reset asserted at data bit 4 of a frame, line then idle -> all outputs at reset values, next full frame 8'h5A received correctly.
